// File: rtl/dragster_pkg.sv
// Shared frame layout, FSM states and counter helper for the Dragster SPI responder.
package dragster_pkg;

   localparam int FRAME_BITS      = 16;
   localparam int DATA_MSB        = 15;
   localparam int DATA_LSB        = 8;
   localparam int RD_FLAG_BIT     = 7;
   localparam int ADDR_MSB        = 6;
   localparam int UPDATE_REG_ADDR = 1;
   localparam int UPDATE_BIT      = 7;
   localparam int CNT_WIDTH       = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Bit counter that sticks at FRAME_BITS so overlong frames cannot wrap it.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
      if (cnt == CNT_WIDTH'(FRAME_BITS)) begin
         return cnt;
      end else begin
         return cnt + 5'd1;
      end
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one SPI pin with rising/falling edge detect in the clk domain.
module spi_input_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Synchronizer chain plus one extra flop holding the previous synchronized value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
         prev_r <= RESET_VAL;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign dout = sync_r[SYNC_STAGES-1];
   assign rise = dout & ~prev_r;
   assign fall = ~dout & prev_r;

endmodule

// File: rtl/dragster_spi_responder.sv
// SPI slave terminating 16-bit Dragster configuration frames into an 8-bit register file.
// Readback on MISO is built only when DRAGSTER_SPI_RESP_READBACK_EN is defined.
module dragster_spi_responder
   import dragster_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sclk,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
   output logic [7:0]            reg_rd_data,
   output logic                  wr_valid,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  update_pulse,
   output logic                  frame_error,
   output logic                  busy
);

   logic sclk_s, sclk_rise_s, sclk_fall_s;
   logic ss_s, ss_rise_s, ss_fall_s;
   logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

   state_e                 state_r, state_next_s;
   logic [CNT_WIDTH-1:0]   cnt_r;
   logic [FRAME_BITS-1:0]  rx_sr_r;
   logic [7:0]             regs_r [NUM_REGS];

   logic [ADDR_MSB:0]      addr_s;
   logic [7:0]             data_s;
   logic                   rd_flag_s;
   logic                   frame_ok_s, addr_ok_s;
   logic                   commit_write_s, commit_read_s, commit_error_s, update_s;

   logic                   wr_valid_r, update_r, frame_error_r, busy_r;
   logic [ADDR_WIDTH-1:0]  wr_addr_r;
   logic [7:0]             wr_data_r;

   // ss_n chain resets low so a select already asserted at reset release never looks like a falling edge.
   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .din(sclk),
      .dout(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s));

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
      .clk(clk), .reset_n(reset_n), .din(ss_n),
      .dout(ss_s), .rise(ss_rise_s), .fall(ss_fall_s));

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset_n(reset_n), .din(mosi),
      .dout(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ss_fall_s) state_next_s = ST_SHIFT;
            else           state_next_s = ST_IDLE;
         end
         ST_SHIFT: begin
            if (ss_rise_s) state_next_s = ST_COMMIT;
            else           state_next_s = ST_SHIFT;
         end
         ST_COMMIT: state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // Receive shifter and saturating bit counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r   <= 5'd0;
         rx_sr_r <= 16'h0000;
      end else if (state_r == ST_IDLE && ss_fall_s) begin
         cnt_r   <= 5'd0;
         rx_sr_r <= 16'h0000;
      end else if (state_r == ST_SHIFT && sclk_rise_s) begin
         if (cnt_r != 5'(FRAME_BITS)) begin
            rx_sr_r <= {rx_sr_r[FRAME_BITS-2:0], mosi_s};
         end else begin
            rx_sr_r <= rx_sr_r;
         end
         cnt_r <= sat_inc(cnt_r);
      end else begin
         cnt_r   <= cnt_r;
         rx_sr_r <= rx_sr_r;
      end
   end

   assign addr_s     = rx_sr_r[ADDR_MSB:0];
   assign data_s     = rx_sr_r[DATA_MSB:DATA_LSB];
   assign frame_ok_s = (cnt_r == 5'(FRAME_BITS));
   assign addr_ok_s  = ({1'b0, addr_s} < 8'(NUM_REGS));

`ifdef DRAGSTER_SPI_RESP_READBACK_EN
   assign rd_flag_s = rx_sr_r[RD_FLAG_BIT];
`else
   assign rd_flag_s = 1'b0;
`endif

   // FSM output decode: what the COMMIT cycle does with the captured frame.
   always_comb begin
      commit_write_s = 1'b0;
      commit_read_s  = 1'b0;
      commit_error_s = 1'b0;
      if (state_r == ST_COMMIT) begin
         if (!frame_ok_s || !addr_ok_s) begin
            commit_error_s = 1'b1;
         end else if (rd_flag_s) begin
            commit_read_s = 1'b1;
         end else begin
            commit_write_s = 1'b1;
         end
      end else begin
         commit_write_s = 1'b0;
      end
   end

   assign update_s = commit_write_s && (addr_s == 7'(UPDATE_REG_ADDR)) && data_s[UPDATE_BIT];

   // Register file, write reporting and strobes, all registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 8'h00;
         end
         wr_valid_r    <= 1'b0;
         update_r      <= 1'b0;
         frame_error_r <= 1'b0;
         busy_r        <= 1'b0;
         wr_addr_r     <= '0;
         wr_data_r     <= 8'h00;
      end else begin
         wr_valid_r    <= commit_write_s;
         update_r      <= update_s;
         frame_error_r <= commit_error_s;
         busy_r        <= (state_next_s != ST_IDLE);
         if (commit_write_s) begin
            regs_r[addr_s[ADDR_WIDTH-1:0]] <= data_s;
            wr_addr_r                      <= addr_s[ADDR_WIDTH-1:0];
            wr_data_r                      <= data_s;
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
         end
      end
   end

   assign reg_rd_data  = regs_r[reg_rd_addr];
   assign wr_valid     = wr_valid_r;
   assign wr_addr      = wr_addr_r;
   assign wr_data      = wr_data_r;
   assign update_pulse = update_r;
   assign frame_error  = frame_error_r;
   assign busy         = busy_r;

`ifdef DRAGSTER_SPI_RESP_READBACK_EN
   logic       rb_pending_r, miso_r, miso_oe_r;
   logic [7:0] rb_data_r, tx_sr_r;

   // Readback latch and MISO shifter; the pending byte is consumed by the next frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rb_pending_r <= 1'b0;
         rb_data_r    <= 8'h00;
         tx_sr_r      <= 8'h00;
         miso_r       <= 1'b0;
         miso_oe_r    <= 1'b0;
      end else begin
         miso_oe_r <= (state_next_s == ST_SHIFT);
         if (commit_read_s) begin
            rb_pending_r <= 1'b1;
            rb_data_r    <= regs_r[addr_s[ADDR_WIDTH-1:0]];
         end else if (state_r == ST_IDLE && ss_fall_s) begin
            rb_pending_r <= 1'b0;
         end else begin
            rb_pending_r <= rb_pending_r;
         end
         if (state_r == ST_IDLE && ss_fall_s) begin
            miso_r  <= rb_pending_r & rb_data_r[7];
            tx_sr_r <= rb_pending_r ? {rb_data_r[6:0], 1'b0} : 8'h00;
         end else if (state_r == ST_SHIFT && sclk_fall_s) begin
            miso_r  <= tx_sr_r[7];
            tx_sr_r <= {tx_sr_r[6:0], 1'b0};
         end else if (state_r == ST_SHIFT) begin
            miso_r  <= miso_r;
            tx_sr_r <= tx_sr_r;
         end else begin
            miso_r  <= 1'b0;
            tx_sr_r <= tx_sr_r;
         end
      end
   end

   assign miso    = miso_r;
   assign miso_oe = miso_oe_r;

   logic unused_sync_s;
   assign unused_sync_s = ^{sclk_s, ss_s, mosi_rise_unused_s, mosi_fall_unused_s};
`else
   assign miso    = 1'b0;
   assign miso_oe = 1'b0;

   logic unused_sync_s;
   assign unused_sync_s = ^{sclk_s, ss_s, mosi_rise_unused_s, mosi_fall_unused_s,
                            sclk_fall_s, commit_read_s, rx_sr_r[RD_FLAG_BIT]};
`endif

endmodule
